// File: rtl/pdua_alu_pkg.sv
// Shared definitions for the PDUA ALU: opcodes, flag bit positions, FSM states.
// The multiplier is enabled by defining PDUA_ALU_MUL_EN.
package pdua_alu_pkg;

  localparam int unsigned OP_PASSB = 0;
  localparam int unsigned OP_ADD   = 1;
  localparam int unsigned OP_SUB   = 2;
  localparam int unsigned OP_AND   = 3;
  localparam int unsigned OP_OR    = 4;
  localparam int unsigned OP_XOR   = 5;
  localparam int unsigned OP_NOTA  = 6;
  localparam int unsigned OP_SHL   = 7;
  localparam int unsigned OP_SHR   = 8;
  localparam int unsigned OP_INC   = 9;
  localparam int unsigned OP_DEC   = 10;
  localparam int unsigned OP_MUL   = 11;

  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned FLAG_Z    = 3;
  localparam int unsigned FLAG_N    = 2;
  localparam int unsigned FLAG_C    = 1;
  localparam int unsigned FLAG_V    = 0;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } state_e;

  function automatic logic [NUM_FLAGS-1:0] make_flags(input logic z, input logic n,
                                                      input logic c, input logic v);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/pdua_alu_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// Only instantiated when PDUA_ALU_MUL_EN is defined.
module pdua_alu_mul #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic [2*W-1:0] acc_q, mcand_q, acc_next;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Product and done look ahead by one step so the owner can register the
  // final value on the same edge as the last accumulation.
  assign product = acc_next;
  assign done    = step && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pdua_alu.sv
// Sequential ALU with registered result/flags and start/busy/done handshake.
// Define PDUA_ALU_MUL_EN to enable the multi-cycle MUL opcode.
module pdua_alu
  import pdua_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic [NUM_FLAGS-1:0]  flags,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W = DATA_WIDTH;

  logic [W:0]           add_ab, sub_ab, inc_a, dec_a;
  logic [W-1:0]         alu_res;
  logic                 alu_c, alu_v, legal;
  logic                 single_go;
  logic [W-1:0]         result_q;
  logic [NUM_FLAGS-1:0] flags_q;
  logic                 done_q;

  // Bit W of the subtract results is the unsigned borrow.
  assign add_ab = {1'b0, a_data} + {1'b0, b_data};
  assign sub_ab = {1'b0, a_data} - {1'b0, b_data};
  assign inc_a  = {1'b0, a_data} + (W + 1)'(1);
  assign dec_a  = {1'b0, a_data} - (W + 1)'(1);

`ifdef PDUA_ALU_MUL_EN
  logic is_mul;
`endif

  always_comb begin
    alu_res = a_data;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    legal   = 1'b1;
`ifdef PDUA_ALU_MUL_EN
    is_mul  = 1'b0;
`endif
    case (op)
      OP_WIDTH'(OP_PASSB): alu_res = b_data;
      OP_WIDTH'(OP_ADD): begin
        alu_res = add_ab[W-1:0];
        alu_c   = add_ab[W];
        alu_v   = (a_data[W-1] == b_data[W-1]) && (add_ab[W-1] != a_data[W-1]);
      end
      OP_WIDTH'(OP_SUB): begin
        alu_res = sub_ab[W-1:0];
        alu_c   = sub_ab[W];
        alu_v   = (a_data[W-1] != b_data[W-1]) && (sub_ab[W-1] != a_data[W-1]);
      end
      OP_WIDTH'(OP_AND):  alu_res = a_data & b_data;
      OP_WIDTH'(OP_OR):   alu_res = a_data | b_data;
      OP_WIDTH'(OP_XOR):  alu_res = a_data ^ b_data;
      OP_WIDTH'(OP_NOTA): alu_res = ~a_data;
      OP_WIDTH'(OP_SHL): begin
        alu_res = {a_data[W-2:0], 1'b0};
        alu_c   = a_data[W-1];
      end
      OP_WIDTH'(OP_SHR): begin
        alu_res = {1'b0, a_data[W-1:1]};
        alu_c   = a_data[0];
      end
      OP_WIDTH'(OP_INC): begin
        alu_res = inc_a[W-1:0];
        alu_c   = inc_a[W];
        alu_v   = !a_data[W-1] && inc_a[W-1];
      end
      OP_WIDTH'(OP_DEC): begin
        alu_res = dec_a[W-1:0];
        alu_c   = dec_a[W];
        alu_v   = a_data[W-1] && !dec_a[W-1];
      end
`ifdef PDUA_ALU_MUL_EN
      OP_WIDTH'(OP_MUL): is_mul = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

`ifdef PDUA_ALU_MUL_EN
  state_e         state_q;
  logic [W-1:0]   result_hi_q;
  logic           mul_load, mul_step, mul_done;
  logic [2*W-1:0] product;

  assign mul_step  = (state_q == StMul);
  assign mul_load  = start && (state_q == StIdle) && is_mul;
  assign single_go = start && (state_q == StIdle) && !is_mul;
  assign busy      = mul_step;
  assign result_hi = result_hi_q;

  pdua_alu_mul #(
    .W(W)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .step   (mul_step),
    .a      (a_data),
    .b      (b_data),
    .product(product),
    .done   (mul_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      result_hi_q <= '0;
    end else begin
      if (single_go) result_hi_q <= '0;
      if (mul_done) result_hi_q <= product[2*W-1:W];
      if (mul_load) state_q <= StMul;
      else if (mul_done) state_q <= StIdle;
    end
  end
`else
  assign single_go = start;
  assign busy      = 1'b0;
  assign result_hi = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (single_go) begin
        result_q <= alu_res;
        done_q   <= 1'b1;
        if (legal) flags_q <= make_flags(alu_res == '0, alu_res[W-1], alu_c, alu_v);
      end
`ifdef PDUA_ALU_MUL_EN
      if (mul_done) begin
        result_q <= product[W-1:0];
        done_q   <= 1'b1;
        flags_q  <= make_flags(product == '0, product[2*W-1], |product[2*W-1:W],
                               |product[2*W-1:W]);
      end
`endif
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pdua_alu.sv
// Directed self-checking bench for pdua_alu; MUL steps run when PDUA_ALU_MUL_EN is defined.
module tb_pdua_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] op;
  logic [7:0] a_data, b_data;
  logic [7:0] result, result_hi;
  logic [3:0] flags;
  logic       busy, done;

  int total = 0;
  int bad   = 0;

  pdua_alu #(
    .DATA_WIDTH(8),
    .OP_WIDTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a_data   (a_data),
    .b_data   (b_data),
    .result   (result),
    .result_hi(result_hi),
    .flags    (flags),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issue a single-cycle op and check the outputs in the following cycle.
  task automatic run1(input string tag, input logic [3:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
    start  = 1'b1;
    op     = o;
    a_data = a;
    b_data = b;
    tick();
    start = 1'b0;
    chk({tag, ".done"}, 16'(done), 16'h1);
    chk({tag, ".result"}, 16'(result), 16'(er));
    chk({tag, ".flags"}, 16'(flags), 16'(ef));
    chk({tag, ".hi"}, 16'(result_hi), 16'h0);
    chk({tag, ".busy"}, 16'(busy), 16'h0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op     = 4'd0;
    a_data = 8'h00;
    b_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.result", 16'(result), 16'h0);
    chk("rst.hi", 16'(result_hi), 16'h0);
    chk("rst.flags", 16'(flags), 16'h0);
    chk("rst.busy", 16'(busy), 16'h0);
    chk("rst.done", 16'(done), 16'h0);

    // flags are {Z,N,C,V}
    run1("add7f", 4'd1, 8'h7F, 8'h01, 8'h80, 4'b0101);
    tick();
    chk("add7f.done_drop", 16'(done), 16'h0);
    chk("add7f.hold", 16'(result), 16'h80);

    // Back-to-back: start stays high across these.
    run1("sub00", 4'd2, 8'h00, 8'h01, 8'hFF, 4'b0110);
    run1("dec80", 4'd10, 8'h80, 8'h00, 8'h7F, 4'b0001);
    run1("shr01", 4'd8, 8'h01, 8'h00, 8'h00, 4'b1010);
    run1("shl81", 4'd7, 8'h81, 8'h00, 8'h02, 4'b0010);
    run1("and", 4'd3, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    run1("or", 4'd4, 8'hF0, 8'h0F, 8'hFF, 4'b0100);
    run1("xor", 4'd5, 8'hAA, 8'hAA, 8'h00, 4'b1000);
    run1("nota", 4'd6, 8'h0F, 8'h55, 8'hF0, 4'b0100);
    run1("passb", 4'd0, 8'h12, 8'h00, 8'h00, 4'b1000);
    run1("incff", 4'd9, 8'hFF, 8'h00, 8'h00, 4'b1010);
    run1("inc7f", 4'd9, 8'h7F, 8'h00, 8'h80, 4'b0101);
    run1("addff", 4'd1, 8'hFF, 8'h01, 8'h00, 4'b1010);
    run1("sub80", 4'd2, 8'h80, 8'h01, 8'h7F, 4'b0001);
    // Illegal opcode: result = A, flags keep 0001 from the previous op.
    run1("ill12", 4'd12, 8'h3C, 8'h99, 8'h3C, 4'b0001);
    run1("ill15", 4'd15, 8'hC3, 8'h00, 8'hC3, 4'b0001);
    tick();
    chk("ill.done_drop", 16'(done), 16'h0);

`ifdef PDUA_ALU_MUL_EN
    // MUL 0x0F * 0x11 = 0x00FF, with an ADD start at n+3 that must be ignored.
    start  = 1'b1;
    op     = 4'd11;
    a_data = 8'h0F;
    b_data = 8'h11;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("mul0f.busy%0d", k), 16'(busy), 16'h1);
      chk($sformatf("mul0f.done%0d", k), 16'(done), 16'h0);
      start = (k == 3);
      op    = (k == 3) ? 4'd1 : 4'd11;
      tick();
      start = 1'b0;
    end
    chk("mul0f.done", 16'(done), 16'h1);
    chk("mul0f.busy_end", 16'(busy), 16'h0);
    chk("mul0f.result", 16'(result), 16'hFF);
    chk("mul0f.hi", 16'(result_hi), 16'h00);
    chk("mul0f.flags", 16'(flags), 16'h0);
    tick();
    chk("mul0f.no_queue", 16'(done), 16'h0);
    chk("mul0f.hold", 16'(result), 16'hFF);

    // MUL 0xFF * 0xFF = 0xFE01.
    start  = 1'b1;
    op     = 4'd11;
    a_data = 8'hFF;
    b_data = 8'hFF;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    chk("mulff.done", 16'(done), 16'h1);
    chk("mulff.result", 16'(result), 16'h01);
    chk("mulff.hi", 16'(result_hi), 16'hFE);
    chk("mulff.flags", 16'(flags), 16'b0111);
    // A following single-cycle op clears the high half.
    run1("add_after_mul", 4'd1, 8'h01, 8'h01, 8'h02, 4'b0000);

    // Reset at n+4 aborts the multiply.
    start  = 1'b1;
    op     = 4'd11;
    a_data = 8'hFF;
    b_data = 8'hFF;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    chk("abort.busy_pre", 16'(busy), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", 16'(busy), 16'h0);
    chk("abort.done", 16'(done), 16'h0);
    chk("abort.result", 16'(result), 16'h0);
    chk("abort.hi", 16'(result_hi), 16'h0);
    chk("abort.flags", 16'(flags), 16'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("abort.quiet%0d", k), 16'({busy, done}), 16'h0);
    end
`else
    // Without the multiplier opcode 11 is illegal and busy never rises.
    run1("sub_setup", 4'd2, 8'h80, 8'h01, 8'h7F, 4'b0001);
    tick();
    chk("nomul.idle", 16'(done), 16'h0);
    start  = 1'b1;
    op     = 4'd11;
    a_data = 8'h3C;
    b_data = 8'h11;
    chk("nomul.busy_n", 16'(busy), 16'h0);
    tick();
    start = 1'b0;
    chk("nomul.done", 16'(done), 16'h1);
    chk("nomul.result", 16'(result), 16'h3C);
    chk("nomul.hi", 16'(result_hi), 16'h0);
    chk("nomul.flags", 16'(flags), 16'b0001);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("nomul.busy%0d", k), 16'(busy), 16'h0);
      tick();
    end
    chk("nomul.done_drop", 16'(done), 16'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
